// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcode/funct
// constants, ALU control codes and datapath mux encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_e;

  // Which kind of ALU operation the current state asks for.
  typedef enum logic [1:0] {AC_NONE, AC_ADD, AC_SUB, AC_FUNCT} alu_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath bundle: IR fields and status in, enables/selects out.
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic       instr_done;
  logic       halted;
  logic       mem_timeout;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, instr_done,
           halted, mem_timeout
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_src, iord, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, instr_done,
           halted, mem_timeout
  );
endinterface

// File: rtl/mc_control_alu_decoder.sv
// Maps the state's ALU class and the R-type funct field to an ALU control code;
// funct_valid tells DECODE whether the R-type op is supported.
module alu_decoder
  import mc_pkg::*;
(
  input  alu_class_e alu_class,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_valid
);

  logic [2:0] funct_ctrl;

  always_comb begin
    funct_valid = 1'b1;
    funct_ctrl  = ALU_AND;
    case (funct)
      FN_ADD:  funct_ctrl = ALU_ADD;
      FN_SUB:  funct_ctrl = ALU_SUB;
      FN_AND:  funct_ctrl = ALU_AND;
      FN_OR:   funct_ctrl = ALU_OR;
      FN_SLT:  funct_ctrl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl = 3'b000;
    case (alu_class)
      AC_ADD:   alu_ctrl = ALU_ADD;
      AC_SUB:   alu_ctrl = ALU_SUB;
      AC_FUNCT: alu_ctrl = funct_ctrl;
      default:  alu_ctrl = 3'b000;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute over several
// cycles, stalls on mem_ready, halts on unsupported opcodes or memory timeout.
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  state_e     state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
  ctrl_t      ctrl, ctrl_o;
  alu_class_e alu_class;
  logic [2:0] alu_ctrl;
  logic       funct_valid;

  alu_decoder u_alu_dec (
    .alu_class   (alu_class),
    .funct       (bus.funct),
    .alu_ctrl    (alu_ctrl),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // ALU class depends on state only, keeping the decoder out of the FSM loop.
  always_comb begin
    alu_class = AC_NONE;
    case (state_q)
      S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: alu_class = AC_ADD;
      S_BRANCH:                              alu_class = AC_SUB;
      S_EXEC:                                alu_class = AC_FUNCT;
      default:                               alu_class = AC_NONE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    timeout_d = timeout_q;
    ctrl      = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PCSRC_PC4;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_RTYPE:     state_d = funct_valid ? S_EXEC : S_HALT;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (bus.mem_ready) begin
          ctrl.instr_done = 1'b1;
          state_d         = S_FETCH;
        end
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.pc_src     = PCSRC_BR;
        ctrl.pc_write   = bus.zero;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_JMP;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: state_d = S_HALT;
    endcase

    // Consecutive not-ready cycles in a memory state; the limit overrides stalling.
    if (is_mem_state(state_q) && !bus.mem_ready) begin
      if (wait_q == CW'(MEM_WAIT_MAX - 1)) begin
        state_d   = S_HALT;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  // Reset is asynchronous, so gate outputs directly to kill strobes immediately.
  always_comb begin
    ctrl_o = reset ? '0 : ctrl;
  end

  assign bus.pc_write    = ctrl_o.pc_write;
  assign bus.pc_src      = ctrl_o.pc_src;
  assign bus.iord        = ctrl_o.iord;
  assign bus.mem_read    = ctrl_o.mem_read;
  assign bus.mem_write   = ctrl_o.mem_write;
  assign bus.ir_write    = ctrl_o.ir_write;
  assign bus.reg_write   = ctrl_o.reg_write;
  assign bus.reg_dst     = ctrl_o.reg_dst;
  assign bus.mem_to_reg  = ctrl_o.mem_to_reg;
  assign bus.alu_src_a   = ctrl_o.alu_src_a;
  assign bus.alu_src_b   = ctrl_o.alu_src_b;
  assign bus.instr_done  = ctrl_o.instr_done;
  assign bus.halted      = ctrl_o.halted;
  assign bus.alu_ctrl    = reset ? 3'b000 : alu_ctrl;
  assign bus.mem_timeout = reset ? 1'b0 : timeout_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-instruction expected output cycles are
// queued by the stimulus and compared by an independent negedge monitor.
module tb_mc_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_control_if bus();

  mc_control #(.MEM_WAIT_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       instr_done;
    logic       halted;
    logic       mem_timeout;
  } exp_t;

  exp_t  expq[$];
  string tagq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic exp_t sample();
    exp_t a;
    a.pc_write = bus.pc_write;     a.pc_src = bus.pc_src;
    a.iord = bus.iord;             a.mem_read = bus.mem_read;
    a.mem_write = bus.mem_write;   a.ir_write = bus.ir_write;
    a.reg_write = bus.reg_write;   a.reg_dst = bus.reg_dst;
    a.mem_to_reg = bus.mem_to_reg; a.alu_src_a = bus.alu_src_a;
    a.alu_src_b = bus.alu_src_b;   a.alu_ctrl = bus.alu_ctrl;
    a.instr_done = bus.instr_done; a.halted = bus.halted;
    a.mem_timeout = bus.mem_timeout;
    return a;
  endfunction

  // Monitor: one expected output vector per clock cycle.
  initial begin
    exp_t e, a;
    string t;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        t = tagq.pop_front();
        a = sample();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", t, a, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Reference ALU code for R-type funct; -1 means unsupported.
  function automatic int funct_code(input logic [5:0] fn);
    case (fn)
      6'b100000: return 2;   // add 010
      6'b100010: return 6;   // sub 110
      6'b100100: return 0;   // and 000
      6'b100101: return 1;   // or  001
      6'b101010: return 7;   // slt 111
      default:   return -1;
    endcase
  endfunction

  task automatic cyc(input exp_t e, input string tag, input logic mr, input logic z);
    bus.mem_ready = mr;
    bus.zero      = z;
    expq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk); #1;
  endtask

  // n not-ready cycles in a memory state; the 15th one halts with timeout.
  task automatic mem_wait(input exp_t e, input string tag, input int n, output bit to);
    to = 0;
    for (int i = 0; i < n && i < 15; i++) cyc(e, tag, 1'b0, rb());
    if (n >= 15) to = 1;
  endtask

  task automatic halt_tail(input logic to);
    exp_t e;
    e = '0; e.halted = 1'b1; e.mem_timeout = to;
    for (int i = 0; i < 4; i++) cyc(e, "halt", rb(), rb());
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.opcode = 6'($urandom); bus.funct = 6'($urandom);
      cyc(exp_t'(0), "reset", rb(), rb());
    end
    reset = 1'b0;
  endtask

  // Behavioural model of one instruction: expected cycle-by-cycle outputs.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int fw, input int mw, input bit abort, output bit hlt);
    exp_t e;
    bit   to;
    int   fc;
    hlt = 0;
    bus.opcode = op; bus.funct = fn;
    fc = funct_code(fn);
    e = '0; e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_ctrl = 3'b010;
    mem_wait(e, "fetch_wait", fw, to);
    if (to) begin halt_tail(1'b1); hlt = 1; return; end
    e.ir_write = 1; e.pc_write = 1;
    cyc(e, "fetch", 1'b1, rb());
    e = '0; e.alu_src_b = 2'b11; e.alu_ctrl = 3'b010;
    cyc(e, "decode", rb(), rb());
    if (op == 6'b000000 && fc >= 0) begin
      e = '0; e.alu_src_a = 1; e.alu_ctrl = fc[2:0];
      cyc(e, "exec", rb(), rb());
      e = '0; e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1;
      cyc(e, "aluwb", rb(), rb());
    end else if (op == 6'b100011 || op == 6'b101011) begin
      e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010;
      cyc(e, "memadr", rb(), rb());
      e = '0; e.iord = 1;
      if (op == 6'b100011) e.mem_read = 1; else e.mem_write = 1;
      if (abort) begin
        bus.mem_ready = 1'b0;
        expq.push_back(e); tagq.push_back("memwr_before_abort");
        @(negedge clk); #1;
        reset = 1'b1; #1;
        chk("abort_mem_write", int'(bus.mem_write), 0);
        chk("abort_mem_read", int'(bus.mem_read), 0);
        @(posedge clk); #1;
        do_reset(1);
        return;
      end
      mem_wait(e, "mem_wait", mw, to);
      if (to) begin halt_tail(1'b1); hlt = 1; return; end
      if (op == 6'b101011) begin
        e.instr_done = 1;
        cyc(e, "memwr", 1'b1, rb());
      end else begin
        cyc(e, "memrd", 1'b1, rb());
        e = '0; e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1;
        cyc(e, "memwb", rb(), rb());
      end
    end else if (op == 6'b000100) begin
      e = '0; e.alu_src_a = 1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01;
      e.pc_write = z; e.instr_done = 1;
      cyc(e, "branch", rb(), z);
    end else if (op == 6'b001000) begin
      e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010;
      cyc(e, "addiex", rb(), rb());
      e = '0; e.reg_write = 1; e.instr_done = 1;
      cyc(e, "addiwb", rb(), rb());
    end else if (op == 6'b000010) begin
      e = '0; e.pc_write = 1; e.pc_src = 2'b10; e.instr_done = 1;
      cyc(e, "jump", rb(), rb());
    end else begin
      halt_tail(1'b0);
      hlt = 1;
    end
  endtask

  logic [11:0] tbl [0:10];

  initial begin
    bit h;
    int k;
    tbl[0] = {6'b000000, 6'b100000}; tbl[1] = {6'b000000, 6'b100010};
    tbl[2] = {6'b000000, 6'b100100}; tbl[3] = {6'b000000, 6'b100101};
    tbl[4] = {6'b000000, 6'b101010}; tbl[5] = {6'b100011, 6'b000000};
    tbl[6] = {6'b101011, 6'b000000}; tbl[7] = {6'b000100, 6'b000000};
    tbl[8] = {6'b001000, 6'b000000}; tbl[9] = {6'b000010, 6'b000000};
    tbl[10] = {6'b010001, 6'b000000};
    reset = 1'b1;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(2);

    do_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 0, h);   // add
    do_instr(6'b100011, 6'b000000, 1'b0, 0, 2, 0, h);   // lw, 2 waits
    do_instr(6'b000100, 6'b000000, 1'b1, 0, 0, 0, h);   // beq taken
    do_instr(6'b000100, 6'b000000, 1'b0, 0, 0, 0, h);   // beq not taken
    do_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 0, h);   // j
    do_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 0, h);   // bad opcode
    do_reset(2);
    do_instr(6'b000000, 6'b000001, 1'b0, 0, 0, 0, h);   // bad funct
    do_reset(2);
    do_instr(6'b000000, 6'b100000, 1'b0, 15, 0, 0, h);  // fetch timeout
    do_reset(2);
    do_instr(6'b000000, 6'b100010, 1'b0, 14, 0, 0, h);  // one short of limit
    do_instr(6'b100011, 6'b000000, 1'b0, 0, 15, 0, h);  // memrd timeout
    do_reset(2);
    do_instr(6'b101011, 6'b000000, 1'b0, 0, 14, 0, h);  // sw, long wait
    do_instr(6'b101011, 6'b000000, 1'b0, 1, 0, 1, h);   // reset mid-MEMWR
    do_instr(6'b000000, 6'b101010, 1'b0, 0, 0, 0, h);

    for (int i = 0; i < 80; i++) begin
      k = ($urandom_range(0, 19) == 0) ? 10 : $urandom_range(0, 9);
      do_instr(tbl[k][11:6], tbl[k][5:0], rb(), $urandom_range(0, 3),
               $urandom_range(0, 3), 0, h);
      if (h) do_reset(1);
    end

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control FSM for the MIPS core. It sequences the shared PC register, memory port, instruction register, register file and ALU over several clock cycles per instruction. It drives every enable and mux select of the multi-cycle datapath, including the PC write enable and PC source select. It stalls on a memory ready handshake and halts on unsupported instructions.

## Interface
Parameters:
- `MEM_WAIT_MAX`, default 15: maximum consecutive `mem_ready=0` cycles tolerated in a memory state before `mem_timeout` asserts.

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `opcode` input 6: IR[31:26], valid from DECODE onward.
- `funct` input 6: IR[5:0].
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write` output 1: PC load enable.
- `pc_src` output 2: 00 = ALU result (PC+4), 01 = ALUOut (branch target), 10 = jump address.
- `iord` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` output 1: memory strobes.
- `ir_write` output 1: instruction register load enable.
- `reg_write` output 1: register file write enable.
- `reg_dst` output 1: 1 = rd, 0 = rt.
- `mem_to_reg` output 1: 1 = MDR, 0 = ALUOut.
- `alu_src_a` output 1: 0 = PC, 1 = A.
- `alu_src_b` output 2: 00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- `alu_ctrl` output 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `instr_done` output 1: one-cycle pulse on the last cycle of each instruction.
- `halted` output 1: FSM is in HALT.
- `mem_timeout` output 1: sticky; set when the wait limit is exceeded.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT.
- FETCH: `mem_read=1`, `iord=0`, `alu_src_a=0`, `alu_src_b=01`, add. While `mem_ready=1`, assert `ir_write=1` and `pc_write=1` with `pc_src=00`, then go to DECODE. Otherwise stay.
- DECODE: `alu_src_a=0`, `alu_src_b=11`, add (precomputes the branch target). Dispatch on opcode:
  - 000000 with a supported funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt) → EXEC.
  - 100011 lw, 101011 sw → MEMADR.
  - 000100 beq → BRANCH.
  - 001000 addi → ADDIEX.
  - 000010 j → JUMP.
  - anything else → HALT.
- MEMADR: `alu_src_a=1`, `alu_src_b=10`, add. lw → MEMRD; sw → MEMWR.
- MEMRD: `mem_read=1`, `iord=1`; wait for `mem_ready`, then → MEMWB.
- MEMWB: `reg_write=1`, `reg_dst=0`, `mem_to_reg=1`, `instr_done=1`; → FETCH.
- MEMWR: `mem_write=1`, `iord=1`; on `mem_ready`: `instr_done=1`, → FETCH.
- EXEC: `alu_src_a=1`, `alu_src_b=00`, `alu_ctrl` from funct; → ALUWB.
- ALUWB: `reg_write=1`, `reg_dst=1`, `mem_to_reg=0`, `instr_done=1`; → FETCH.
- BRANCH: `alu_src_a=1`, `alu_src_b=00`, sub, `pc_src=01`, `pc_write=zero`, `instr_done=1`; → FETCH.
- ADDIEX: `alu_src_a=1`, `alu_src_b=10`, add; → ADDIWB.
- ADDIWB: `reg_write=1`, `reg_dst=0`, `mem_to_reg=0`, `instr_done=1`; → FETCH.
- JUMP: `pc_write=1`, `pc_src=10`, `instr_done=1`; → FETCH.
- HALT: all enables 0, `halted=1`. Only reset exits.
- Unlisted outputs default to 0.
- The wait counter counts consecutive `mem_ready=0` cycles in FETCH/MEMRD/MEMWR. It clears on `mem_ready=1` and on leaving the state. When the count reaches `MEM_WAIT_MAX`, set `mem_timeout` and go to HALT.

## Timing
- While `reset` is high: state = FETCH, wait counter = 0, `mem_timeout=0`, and all enables/strobes (`pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write`) are forced to 0. All other outputs are 0.
- The first fetch is on the first rising edge after reset deasserts.
- Outputs are decoded from the state register. `pc_write` in BRANCH (from `zero`) and the FETCH/MEMWR completion signals (from `mem_ready`) are combinational on those inputs.
- Latency with zero-wait memory, counting FETCH through the final state inclusive:
  - j: 3 cycles
  - beq: 3 cycles
  - sw: 4 cycles
  - R-type: 4 cycles
  - addi: 4 cycles
  - lw: 5 cycles
- Each `mem_ready=0` cycle in a memory state adds one cycle.
- Reset asserted mid-instruction aborts it immediately with no partial writes. The PC is not written by this block during reset.
- `instr_done` pulses exactly once per retired instruction and never in HALT.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - opcode and funct constants;
  - `alu_ctrl` codes;
  - `pc_src` and `alu_src_b` encodings.
- Sub-module `alu_decoder` maps (state-class, funct) → `alu_ctrl` plus a `funct_valid` flag used by the DECODE dispatch.

## Test plan
- Reset, then R-type add (`opcode=000000`, `funct=100000`) with `mem_ready=1` → states FETCH, DECODE, EXEC, ALUWB. `pc_write` high only in FETCH; `reg_write=1`, `reg_dst=1` in cycle 4.
- lw with `mem_ready` low for 2 cycles in MEMRD → 7 cycles total, `mem_read=1`, `iord=1` throughout MEMRD, `mem_to_reg=1` in MEMWB.
- beq with `zero=1`, then beq with `zero=0` → `pc_write=1`, `pc_src=01` in BRANCH for the first; `pc_write=0` for the second; 3 cycles each.
- j → `pc_write=1`, `pc_src=10` in cycle 3. Opcode 111111 → HALT, `halted=1`, `instr_done` never pulses, FSM stays until reset.
- `mem_ready` held 0 in FETCH for `MEM_WAIT_MAX` (15) cycles → `mem_timeout=1`, HALT.
- Reset asserted mid-MEMWR → `mem_write` drops to 0 immediately. After release, FETCH with `mem_read=1`.
